// File: rtl/mips_cpu_bus_wait_memory.sv
// Byte-addressed, little-endian Avalon-style slave memory for the MIPS CPU
// bus harness: waitrequest stalls, one-cycle registered read return with
// readdatavalid, per-lane byte enables, relocatable base and a sticky
// protocol-error monitor. Memory is zero-filled at time zero; reset does
// not clear it.
// Optional feature macro: MEM_STALL_RANDOM_EN (per-transfer LFSR stall
// length in 0..WAIT_CYCLES instead of a fixed WAIT_CYCLES).
module mips_cpu_bus_wait_memory #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned MEM_BYTES     = 32768,
  parameter logic [31:0] BASE_ADDR     = 32'hBFC00000,
  parameter int unsigned WAIT_CYCLES   = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter string       RAM_INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [3:0]            byteenable,
  input  logic [31:0]           writedata,
  output logic                  waitrequest,
  output logic [31:0]           readdata,
  output logic                  readdatavalid,
  output logic                  protocol_error
);

  localparam int unsigned MEM_WORDS = MEM_BYTES / 4;
  localparam int unsigned WIDX      = $clog2(MEM_WORDS);

  typedef logic [ADDR_WIDTH:0] addr_ext_t;
  typedef logic [WIDX-1:0]     widx_t;

  localparam addr_ext_t ADDR_LO = addr_ext_t'(BASE_ADDR);
  localparam addr_ext_t ADDR_HI = ADDR_LO + addr_ext_t'(MEM_BYTES);

  typedef enum logic {
    PH_IDLE,
    PH_STALL
  } phase_e;

  logic [31:0] mem_q [MEM_WORDS];

  phase_e                phase_q, phase_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            be_q;
  logic [31:0]           wd_q;
  logic [31:0]           readdata_q, readdata_d;
  logic                  readdatavalid_q, readdatavalid_d;
  logic                  perr_q, perr_d;

`ifdef MEM_STALL_RANDOM_EN
  logic [3:0]  t_q, t_d;
  logic [15:0] lfsr_q, lfsr_d;
`endif

  addr_ext_t   addr_ext;
  widx_t       word_idx;
  logic [31:0] lane_mask;
  logic [3:0]  t_cur;
  logic        req, in_range, misaligned, out_of_rng;
  logic        violation, flagged, accept, mem_ok, stalling;

  // Time-zero contents: zero fill; parameter sanity.
  initial begin
    for (int unsigned i = 0; i < MEM_WORDS; i++) mem_q[i] = '0;
    if (LFSR_SEED == 16'h0000) $error("LFSR_SEED must be non-zero");
    if ((MEM_BYTES % 4) != 0)  $error("MEM_BYTES must be a multiple of 4");
    if (WAIT_CYCLES > 15)      $error("WAIT_CYCLES must be 0..15");
  end

  // Request decode, stall target, protocol checks and next-state values.
  always_comb begin
    addr_ext   = {1'b0, address};
    req        = read ^ write;
    in_range   = (addr_ext >= ADDR_LO) && (addr_ext < ADDR_HI);
    misaligned = req && (address[1:0] != 2'b00);
    out_of_rng = req && !in_range;
    word_idx   = widx_t'((addr_ext - ADDR_LO) >> 2);

    lane_mask = '0;
    for (int unsigned i = 0; i < 4; i++) lane_mask[8*i +: 8] = {8{byteenable[i]}};

`ifdef MEM_STALL_RANDOM_EN
    // Stall length is drawn on the first request cycle and frozen while stalling.
    t_cur  = (phase_q == PH_STALL) ? t_q : 4'(lfsr_q[3:0] % (WAIT_CYCLES + 1));
    t_d    = req ? t_cur : t_q;
`else
    t_cur  = 4'(WAIT_CYCLES);
`endif

    waitrequest = req && (cnt_q < t_cur);
    stalling    = req && waitrequest;

    // Master must hold a stalled request unchanged until it is accepted.
    violation = (phase_q == PH_STALL) &&
                (!req || (read != rd_q) || (address != addr_q) ||
                 (byteenable != be_q) || (writedata != wd_q));

    flagged = (read && write) || misaligned || out_of_rng || violation;
    accept  = req && !waitrequest;
    mem_ok  = accept && !flagged;

    if (violation || accept) cnt_d = '0;
    else if (stalling)       cnt_d = cnt_q + 4'd1;
    else                     cnt_d = cnt_q;

    phase_d = stalling ? PH_STALL : PH_IDLE;

    readdata_d      = readdata_q;
    readdatavalid_d = accept && read;
    if (accept && read) readdata_d = mem_ok ? (mem_q[word_idx] & lane_mask) : '0;

    perr_d = perr_q || flagged;

`ifdef MEM_STALL_RANDOM_EN
    lfsr_d = accept ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]}
                    : lfsr_q;
`endif
  end

  // Handshake state, registered outputs and memory writes; reset blocks writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q         <= PH_IDLE;
      cnt_q           <= '0;
      rd_q            <= 1'b0;
      addr_q          <= '0;
      be_q            <= '0;
      wd_q            <= '0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      perr_q          <= 1'b0;
`ifdef MEM_STALL_RANDOM_EN
      t_q             <= '0;
      lfsr_q          <= LFSR_SEED;
`endif
    end else begin
      phase_q         <= phase_d;
      cnt_q           <= cnt_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
      perr_q          <= perr_d;
`ifdef MEM_STALL_RANDOM_EN
      t_q             <= t_d;
      lfsr_q          <= lfsr_d;
`endif
      if (stalling) begin
        rd_q   <= read;
        addr_q <= address;
        be_q   <= byteenable;
        wd_q   <= writedata;
      end
      if (mem_ok && write) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (byteenable[i]) mem_q[word_idx][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

  assign readdata       = readdata_q;
  assign readdatavalid  = readdatavalid_q;
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_mips_cpu_bus_wait_memory.sv
// Bench for mips_cpu_bus_wait_memory: three instances with 0, 2 and 3 wait
// cycles, a vector table, random traffic against a byte-level reference
// memory, and hand sequences for back-to-back reads, reset mid-stall and
// protocol errors.
module tb_mips_cpu_bus_wait_memory;

  localparam int          NI   = 3;
  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_s [NI];
  logic        wr_s [NI];
  logic [31:0] ad_s [NI];
  logic [3:0]  be_s [NI];
  logic [31:0] wd_s [NI];
  logic        wreq   [NI];
  logic [31:0] rdata  [NI];
  logic        rvalid [NI];
  logic        perr   [NI];

  int errors = 0;
  int checks = 0;

  logic [7:0] mem_m [int];

  always #5 clk = ~clk;

  mips_cpu_bus_wait_memory #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset_n(reset_n), .read(rd_s[0]), .write(wr_s[0]), .address(ad_s[0]),
    .byteenable(be_s[0]), .writedata(wd_s[0]), .waitrequest(wreq[0]), .readdata(rdata[0]),
    .readdatavalid(rvalid[0]), .protocol_error(perr[0]));

  mips_cpu_bus_wait_memory #(.WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset_n(reset_n), .read(rd_s[1]), .write(wr_s[1]), .address(ad_s[1]),
    .byteenable(be_s[1]), .writedata(wd_s[1]), .waitrequest(wreq[1]), .readdata(rdata[1]),
    .readdatavalid(rvalid[1]), .protocol_error(perr[1]));

  mips_cpu_bus_wait_memory #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset_n(reset_n), .read(rd_s[2]), .write(wr_s[2]), .address(ad_s[2]),
    .byteenable(be_s[2]), .writedata(wd_s[2]), .waitrequest(wreq[2]), .readdata(rdata[2]),
    .readdatavalid(rvalid[2]), .protocol_error(perr[2]));

  function automatic int wait_of(input int k);
    case (k)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int mkey(input int k, input logic [31:0] a, input int i);
    return k * 65536 + int'(a - BASE) + i;
  endfunction

  function automatic logic [31:0] model_read(input int k, input logic [31:0] a, input logic [3:0] be);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) begin
      if (be[i] && mem_m.exists(mkey(k, a, i))) w[8*i +: 8] = mem_m[mkey(k, a, i)];
    end
    return w;
  endfunction

  task automatic model_write(input int k, input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] wd);
    for (int i = 0; i < 4; i++) if (be[i]) mem_m[mkey(k, a, i)] = wd[8*i +: 8];
  endtask

  task automatic idle(input int k);
    rd_s[k] = 1'b0; wr_s[k] = 1'b0; ad_s[k] = '0; be_s[k] = '0; wd_s[k] = '0;
  endtask

  // Count stall cycles until acceptance (bounded); called just after a posedge.
  task automatic count_stalls(input int k, output int stalls);
    bit done = 1'b0;
    stalls = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!wreq[k]) begin done = 1'b1; break; end
      stalls++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no acceptance expected acceptance within 40 cycles");
    end
  endtask

  // One complete transfer; for reads returns the value seen one cycle after acceptance.
  task automatic xfer(input int k, input bit rd, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd, output int stalls, output bit vld,
                      output logic [31:0] data);
    @(posedge clk); #1;
    rd_s[k] = rd; wr_s[k] = !rd; ad_s[k] = a; be_s[k] = be; wd_s[k] = wd;
    count_stalls(k, stalls);
    @(posedge clk); #1;
    idle(k);
    @(negedge clk);
    vld  = rvalid[k];
    data = rdata[k];
  endtask

  task automatic apply(input string name, input int k, input bit rd, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd, input logic [31:0] exp);
    int stalls; bit vld; logic [31:0] data;
    xfer(k, rd, a, be, wd, stalls, vld, data);
    check({name, "_stalls"}, 32'(stalls), 32'(wait_of(k)));
    check({name, "_valid"}, {31'd0, vld}, {31'd0, rd});
    if (rd) check({name, "_data"}, data, exp);
    else    model_write(k, a, be, wd);
  endtask

  typedef struct {
    int          k;
    bit          rd;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin : main
    vec_t        tbl [16];
    logic [31:0] words [4];
    int          stalls;
    bit          vld;
    logic [31:0] data;

    tbl[0]  = '{1, 1'b0, 32'hBFC00010, 4'b1111, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1, 1'b1, 32'hBFC00010, 4'b1111, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1, 1'b0, 32'hBFC00020, 4'b1111, 32'h00000000, 32'h0};
    tbl[3]  = '{1, 1'b0, 32'hBFC00020, 4'b1010, 32'h11223344, 32'h0};
    tbl[4]  = '{1, 1'b1, 32'hBFC00020, 4'b1111, 32'h0,        32'h11003300};
    tbl[5]  = '{1, 1'b1, 32'hBFC00020, 4'b0001, 32'h0,        32'h00000000};
    tbl[6]  = '{1, 1'b1, 32'hBFC00020, 4'b1000, 32'h0,        32'h11000000};
    tbl[7]  = '{1, 1'b0, 32'hBFC00020, 4'b0000, 32'hFFFFFFFF, 32'h0};
    tbl[8]  = '{1, 1'b1, 32'hBFC00020, 4'b1111, 32'h0,        32'h11003300};
    tbl[9]  = '{2, 1'b0, 32'hBFC00030, 4'b0101, 32'hAABBCCDD, 32'h0};
    tbl[10] = '{2, 1'b1, 32'hBFC00030, 4'b1111, 32'h0,        32'h00BB00DD};
    tbl[11] = '{0, 1'b0, 32'hBFC00040, 4'b1111, 32'h01020304, 32'h0};
    tbl[12] = '{0, 1'b0, 32'hBFC00044, 4'b1111, 32'h05060708, 32'h0};
    tbl[13] = '{0, 1'b0, 32'hBFC00048, 4'b1111, 32'h090A0B0C, 32'h0};
    tbl[14] = '{0, 1'b0, 32'hBFC0004C, 4'b1111, 32'h0D0E0F10, 32'h0};
    tbl[15] = '{0, 1'b1, 32'hBFC00044, 4'b0110, 32'h0,        32'h00060700};
    words = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};

    reset_n = 1'b0;
    for (int k = 0; k < NI; k++) idle(k);
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_readdata%0d", k), rdata[k], 32'h0);
      check($sformatf("rst_valid%0d", k), {31'd0, rvalid[k]}, 32'h0);
      check($sformatf("rst_perr%0d", k), {31'd0, perr[k]}, 32'h0);
      check($sformatf("rst_wait%0d", k), {31'd0, wreq[k]}, 32'h0);
    end
    reset_n = 1'b1;

    foreach (tbl[i])
      apply($sformatf("vec%0d", i), tbl[i].k, tbl[i].rd, tbl[i].a, tbl[i].be, tbl[i].wd,
            tbl[i].exp);

    // Back-to-back reads with no stalls: one readdatavalid per cycle.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      rd_s[0] = 1'b1; wr_s[0] = 1'b0; ad_s[0] = 32'hBFC00040 + 32'(4 * i); be_s[0] = 4'hF;
      @(negedge clk);
      check($sformatf("b2b_wait%0d", i), {31'd0, wreq[0]}, 32'h0);
      if (i > 0) begin
        check($sformatf("b2b_valid%0d", i - 1), {31'd0, rvalid[0]}, 32'h1);
        check($sformatf("b2b_data%0d", i - 1), rdata[0], words[i - 1]);
      end
      @(posedge clk); #1;
    end
    idle(0);
    @(negedge clk);
    check("b2b_valid3", {31'd0, rvalid[0]}, 32'h1);
    check("b2b_data3", rdata[0], words[3]);
    @(negedge clk);
    check("b2b_valid_end", {31'd0, rvalid[0]}, 32'h0);
    check("b2b_hold", rdata[0], words[3]);

    // Random traffic against the reference memory.
    for (int n = 0; n < 60; n++) begin
      int          k  = int'($urandom_range(0, 2));
      bit          rd = 1'($urandom_range(0, 1));
      logic [31:0] a  = 32'hBFC00100 + 32'(4 * $urandom_range(0, 15));
      logic [3:0]  be = 4'($urandom);
      logic [31:0] wd = $urandom;
      apply($sformatf("rnd%0d", n), k, rd, a, be, wd, model_read(k, a, be));
    end

    // Reset during a stall: interrupted write must not land, retry stalls fully.
    @(posedge clk); #1;
    rd_s[2] = 1'b0; wr_s[2] = 1'b1; ad_s[2] = 32'hBFC00200; be_s[2] = 4'hF;
    wd_s[2] = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_wait", {31'd0, wreq[2]}, 32'h1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    be_s[2] = 4'b0001; wd_s[2] = 32'h00000078;
    count_stalls(2, stalls);
    check("retry_stalls", 32'(stalls), 32'd3);
    @(posedge clk); #1;
    idle(2);
    model_write(2, 32'hBFC00200, 4'b0001, 32'h00000078);
    check("rst_perr", {31'd0, perr[2]}, 32'h0);
    apply("after_rst", 2, 1'b1, 32'hBFC00200, 4'hF, 32'h0, model_read(2, 32'hBFC00200, 4'hF));

    // Out-of-range read: zero data, valid pulse, sticky error.
    xfer(0, 1'b1, 32'h00000000, 4'hF, 32'h0, stalls, vld, data);
    check("oor_valid", {31'd0, vld}, 32'h1);
    check("oor_data", data, 32'h0);
    check("oor_perr", {31'd0, perr[0]}, 32'h1);

    // read and write together: no stall, no access, error flagged.
    check("both_perr_before", {31'd0, perr[1]}, 32'h0);
    @(posedge clk); #1;
    rd_s[1] = 1'b1; wr_s[1] = 1'b1; ad_s[1] = 32'hBFC00010; be_s[1] = 4'hF; wd_s[1] = '0;
    @(negedge clk);
    check("both_wait", {31'd0, wreq[1]}, 32'h0);
    @(posedge clk); #1;
    idle(1);
    @(negedge clk);
    check("both_valid", {31'd0, rvalid[1]}, 32'h0);
    check("both_perr", {31'd0, perr[1]}, 32'h1);
    apply("both_nowrite", 1, 1'b1, 32'hBFC00010, 4'hF, 32'h0, 32'hDEADBEEF);

    // Misaligned write is accepted but does not touch memory.
    xfer(2, 1'b0, 32'hBFC00202, 4'hF, 32'hFFFFFFFF, stalls, vld, data);
    check("mis_stalls", 32'(stalls), 32'd3);
    check("mis_perr", {31'd0, perr[2]}, 32'h1);
    apply("mis_nowrite", 2, 1'b1, 32'hBFC00200, 4'hF, 32'h0, 32'h00000078);

    repeat (3) @(negedge clk);
    check("perr_sticky", {31'd0, perr[0]}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
